stock_waste_ctrl: RTL

- Downstream of the deal/setup stage: takes the 24-card talon vector and `ready` it produces, and owns the stock (face-down) and waste (face-up) piles during play.
- Serves DRAW and TAKE commands from the game controller over a valid/ready handshake.
- Performs the Klondike recycle (waste back to stock) as a multi-cycle operation.

---
 rtl/stock_waste_ctrl_pkg.sv | 34 +++
 rtl/stock_waste_ctrl_stack.sv | 77 +++++++
 rtl/stock_waste_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stock_waste_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stock_waste_ctrl_pkg
// Description : Shared constants and types for the stock/waste pile
//               controller: card geometry, suit codes, command opcodes
//               and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package stock_waste_ctrl_pkg;

    // Card layout: [6:3] rank 1..13, [2:1] suit, [0] face-up. All-zero = empty.
    localparam int CARD_SIZE = 7;
    localparam int PILE_SIZE = 24;
    localparam int CNT_W     = 5;

    localparam logic [1:0] HEARTS   = 2'd0;
    localparam logic [1:0] SPADES   = 2'd1;
    localparam logic [1:0] DIAMONDS = 2'd2;
    localparam logic [1:0] CLUBS    = 2'd3;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_DRAW = 2'b01;
    localparam logic [1:0] OP_TAKE = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_PLAY    = 2'd2,
        ST_RECYCLE = 2'd3
    } state_t;

endpackage : stock_waste_ctrl_pkg
`default_nettype wire

// File: rtl/stock_waste_ctrl_stack.sv
`default_nettype none
// ============================================================================
// Module      : card_stack
// Description : Parameterised LIFO of cards with push, pop, combinational
//               top-of-stack view, occupancy count and synchronous clear.
//               Top of stack lives at index count-1; an empty stack shows 0.
// Ports       : clk, rst (async, active-low)
//               i_clr   - synchronous clear (count to zero)
//               i_push  - push i_data (ignored when full, unless popping)
//               i_pop   - pop top (ignored when empty)
//               o_top   - current top entry, 0 when empty
//               o_count - number of entries held
//               o_empty - count == 0
// Revision    : 1.0 - initial release
// ============================================================================
module card_stack #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 24,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;

    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;
    logic [IDX_W-1:0] w_top_idx;
    logic [IDX_W-1:0] w_push_idx;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop & ~w_empty;
    // A simultaneous pop frees the top slot, so a full stack may still accept.
    assign w_do_push = i_push & (~w_full | w_do_pop);
    assign w_top_idx = IDX_W'(r_count - CNT_W'(1));
    assign w_push_idx = w_do_pop ? w_top_idx : IDX_W'(r_count);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clr) begin
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[w_push_idx] <= i_data;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_top   = w_empty ? '0 : r_mem[w_top_idx];
    assign o_count = r_count;
    assign o_empty = w_empty;

endmodule : card_stack
`default_nettype wire

// File: rtl/stock_waste_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stock_waste_ctrl
// Description : Owns the Klondike stock (face-down) and waste (face-up)
//               piles. Loads the talon from the setup stage one slot per
//               cycle, serves DRAW/TAKE commands and performs the
//               multi-cycle waste-to-stock recycle.
// Ports       : clk, rst (async, active-low)
//               i_pile_in     - talon vector, slot i at [i*CARD_SIZE +: CARD_SIZE]
//               i_pile_ready  - talon valid; falling edge aborts the deal
//               i_cmd_valid   - command request
//               i_cmd_op      - 00 NOP, 01 DRAW, 10 TAKE, 11 reserved
//               o_cmd_ready   - high in PLAY only
//               o_resp_valid  - one-cycle pulse with the TAKE result
//               o_resp_card   - card removed by TAKE
//               o_cmd_err     - one-cycle pulse on an illegal command
//               o_waste_top   - waste top card, 0 if empty
//               o_stock_count - cards in stock
//               o_waste_count - cards in waste
//               o_pass_count  - completed recycles, saturating at 15
//               o_busy        - high in LOAD or RECYCLE
// Revision    : 1.0 - initial release
// ============================================================================
module stock_waste_ctrl
    import stock_waste_ctrl_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PILE_SIZE*CARD_SIZE-1:0] i_pile_in,
    input  logic                           i_pile_ready,
    input  logic                           i_cmd_valid,
    input  logic [1:0]                     i_cmd_op,
    output logic                           o_cmd_ready,
    output logic                           o_resp_valid,
    output logic [CARD_SIZE-1:0]           o_resp_card,
    output logic                           o_cmd_err,
    output logic [CARD_SIZE-1:0]           o_waste_top,
    output logic [CNT_W-1:0]               o_stock_count,
    output logic [CNT_W-1:0]               o_waste_count,
    output logic [3:0]                     o_pass_count,
    output logic                           o_busy
);

    localparam logic [CARD_SIZE-1:0] c_FACE_BIT = CARD_SIZE'(1);

    state_t                         r_state;
    state_t                         w_state_nxt;

    logic [PILE_SIZE*CARD_SIZE-1:0] r_shadow;
    logic [CNT_W-1:0]               r_idx;
    logic [3:0]                     r_pass;
    logic                           r_resp_valid;
    logic [CARD_SIZE-1:0]           r_resp_card;
    logic                           r_err;

    logic                           w_capture;
    logic                           w_idx_clr;
    logic                           w_idx_inc;
    logic                           w_pile_clr;
    logic                           w_pass_inc;
    logic                           w_resp_valid_nxt;
    logic [CARD_SIZE-1:0]           w_resp_card_nxt;
    logic                           w_err_nxt;

    logic                           w_stock_push;
    logic                           w_stock_pop;
    logic [CARD_SIZE-1:0]           w_stock_din;
    logic [CARD_SIZE-1:0]           w_stock_top;
    logic [CNT_W-1:0]               w_stock_count;
    logic                           w_stock_empty;

    logic                           w_waste_push;
    logic                           w_waste_pop;
    logic [CARD_SIZE-1:0]           w_waste_din;
    logic [CARD_SIZE-1:0]           w_waste_top;
    logic [CNT_W-1:0]               w_waste_count;
    logic                           w_waste_empty;

    logic [CARD_SIZE-1:0]           w_slot;

    assign w_slot = r_shadow[int'(r_idx)*CARD_SIZE +: CARD_SIZE];

    card_stack #(
        .WIDTH (CARD_SIZE),
        .DEPTH (PILE_SIZE),
        .CNT_W (CNT_W)
    ) u_stock (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_pile_clr),
        .i_push  (w_stock_push),
        .i_pop   (w_stock_pop),
        .i_data  (w_stock_din),
        .o_top   (w_stock_top),
        .o_count (w_stock_count),
        .o_empty (w_stock_empty)
    );

    card_stack #(
        .WIDTH (CARD_SIZE),
        .DEPTH (PILE_SIZE),
        .CNT_W (CNT_W)
    ) u_waste (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_pile_clr),
        .i_push  (w_waste_push),
        .i_pop   (w_waste_pop),
        .i_data  (w_waste_din),
        .o_top   (w_waste_top),
        .o_count (w_waste_count),
        .o_empty (w_waste_empty)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and pile control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_capture        = 1'b0;
        w_idx_clr        = 1'b0;
        w_idx_inc        = 1'b0;
        w_pile_clr       = 1'b0;
        w_pass_inc       = 1'b0;
        w_resp_valid_nxt = 1'b0;
        w_resp_card_nxt  = '0;
        w_err_nxt        = 1'b0;
        w_stock_push     = 1'b0;
        w_stock_pop      = 1'b0;
        w_stock_din      = '0;
        w_waste_push     = 1'b0;
        w_waste_pop      = 1'b0;
        w_waste_din      = '0;

        if (r_state != ST_IDLE && !i_pile_ready) begin
            // Setup withdrew the talon: abandon this deal entirely.
            w_pile_clr  = 1'b1;
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_pile_ready) begin
                        w_capture   = 1'b1;
                        w_idx_clr   = 1'b1;
                        w_state_nxt = ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    // Empty slots still cost a cycle so LOAD length is fixed.
                    if (w_slot != '0) begin
                        w_stock_push = 1'b1;
                        w_stock_din  = w_slot & ~c_FACE_BIT;
                    end
                    if (r_idx == CNT_W'(PILE_SIZE - 1)) begin
                        w_state_nxt = ST_PLAY;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end

                ST_PLAY: begin
                    if (i_cmd_valid) begin
                        case (i_cmd_op)
                            OP_DRAW: begin
                                if (!w_stock_empty) begin
                                    w_stock_pop  = 1'b1;
                                    w_waste_push = 1'b1;
                                    w_waste_din  = w_stock_top | c_FACE_BIT;
                                end else if (!w_waste_empty) begin
                                    w_state_nxt = ST_RECYCLE;
                                end else begin
                                    w_err_nxt = 1'b1;
                                end
                            end
                            OP_TAKE: begin
                                if (!w_waste_empty) begin
                                    w_waste_pop      = 1'b1;
                                    w_resp_valid_nxt = 1'b1;
                                    w_resp_card_nxt  = w_waste_top;
                                end else begin
                                    w_err_nxt = 1'b1;
                                end
                            end
                            OP_RSVD: begin
                                w_err_nxt = 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end

                ST_RECYCLE: begin
                    // Popping waste onto stock reverses the order, so the
                    // earliest drawn card ends up on top of the new stock.
                    if (!w_waste_empty) begin
                        w_waste_pop  = 1'b1;
                        w_stock_push = 1'b1;
                        w_stock_din  = w_waste_top & ~c_FACE_BIT;
                    end
                    if (w_waste_count <= CNT_W'(1)) begin
                        w_pass_inc  = 1'b1;
                        w_state_nxt = ST_PLAY;
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow     <= '0;
            r_idx        <= '0;
            r_pass       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_card  <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_capture) begin
                r_shadow <= i_pile_in;
            end

            if (w_idx_clr) begin
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + CNT_W'(1);
            end

            if (w_pile_clr) begin
                r_pass <= '0;
            end else if (w_pass_inc && r_pass != 4'hF) begin
                r_pass <= r_pass + 4'd1;
            end

            r_resp_valid <= w_resp_valid_nxt;
            r_resp_card  <= w_resp_card_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign o_cmd_ready   = (r_state == ST_PLAY);
    assign o_busy        = (r_state == ST_LOAD) || (r_state == ST_RECYCLE);
    assign o_resp_valid  = r_resp_valid;
    assign o_resp_card   = r_resp_card;
    assign o_cmd_err     = r_err;
    assign o_waste_top   = w_waste_top;
    assign o_stock_count = w_stock_count;
    assign o_waste_count = w_waste_count;
    assign o_pass_count  = r_pass;

endmodule : stock_waste_ctrl
`default_nettype wire
